// File: rtl/pipeline_fetch.sv
// Instruction fetch stage: one outstanding read, redirect drain, optional line buffer.
// Optional feature: define FETCH_LINE_BUFFER_EN to keep the last fetched beat and serve hits from it.
module pipeline_fetch #(
    parameter int                    ADDR_WIDTH = 64,
    parameter int                    DATA_WIDTH = 64,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic                    mem_req,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    input  logic                    mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic                    decode_ready,
    output logic [DATA_WIDTH/2-1:0] instruction,
    output logic [ADDR_WIDTH-1:0]   instruction_pc,
    input  logic                    redirect_valid,
    input  logic [ADDR_WIDTH-1:0]   redirect_pc
);

    // state | meaning
    // FETCH | request outstanding (or line-buffer hit pending), waiting for the word
    // DRAIN | old request still outstanding after a redirect, its data is dropped
    // HOLD  | instruction presented, waiting for decode to take it
    typedef enum logic [1:0] {FETCH, DRAIN, HOLD} state_t;

    localparam int IW = DATA_WIDTH / 2;
    localparam int TW = ADDR_WIDTH - 3;

    state_t                 state, state_nxt;
    logic                   req_en;
    logic [ADDR_WIDTH-1:0]  pc, pc_nxt;
    logic [ADDR_WIDTH-1:0]  pc_inc, redirect_tgt;
    logic [ADDR_WIDTH-1:0]  drain_addr, drain_addr_nxt;
    logic [ADDR_WIDTH-1:0]  instruction_pc_nxt;
    logic [IW-1:0]          instruction_nxt;
    logic [IW-1:0]          word_sel;
    logic [IW-1:0]          buf_word;
    logic                   buf_hit;
    logic                   resp_take;

    assign pc_inc       = pc + ADDR_WIDTH'(4);
    assign redirect_tgt = redirect_pc & ~ADDR_WIDTH'(3);
    assign word_sel     = pc[2] ? mem_rdata[DATA_WIDTH-1:IW] : mem_rdata[IW-1:0];

    // req_en delays the first request by one edge after reset release
    assign mem_req   = req_en && ((state == DRAIN) || ((state == FETCH) && !buf_hit));
    assign mem_addr  = (state == DRAIN) ? drain_addr : {pc[ADDR_WIDTH-1:3], 3'b000};
    assign resp_take = mem_req && mem_resp_valid && (state == FETCH);

`ifdef FETCH_LINE_BUFFER_EN
    logic [DATA_WIDTH-1:0] lb_data;
    logic [TW-1:0]         lb_tag;
    logic                  lb_valid;

    assign buf_hit  = lb_valid && (lb_tag == pc[ADDR_WIDTH-1:3]);
    assign buf_word = pc[2] ? lb_data[DATA_WIDTH-1:IW] : lb_data[IW-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lb_valid <= 1'b0;
            lb_tag   <= '0;
            lb_data  <= '0;
        end else if (resp_take) begin
            lb_valid <= 1'b1;
            lb_tag   <= pc[ADDR_WIDTH-1:3];
            lb_data  <= mem_rdata;
        end
    end
`else
    assign buf_hit  = 1'b0;
    assign buf_word = '0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= FETCH;
            req_en         <= 1'b0;
            pc             <= RESET_PC;
            drain_addr     <= '0;
            instruction    <= '0;
            instruction_pc <= RESET_PC;
        end else begin
            state          <= state_nxt;
            req_en         <= 1'b1;
            pc             <= pc_nxt;
            drain_addr     <= drain_addr_nxt;
            instruction    <= instruction_nxt;
            instruction_pc <= instruction_pc_nxt;
        end
    end

    always_comb begin
        state_nxt          = state;
        pc_nxt             = pc;
        drain_addr_nxt     = drain_addr;
        instruction_nxt    = instruction;
        instruction_pc_nxt = instruction_pc;
        case (state)
            FETCH: begin
                if (redirect_valid) begin
                    pc_nxt          = redirect_tgt;
                    instruction_nxt = '0;
                    // a response in this same cycle closes the request, so no drain is needed
                    if (mem_req && !mem_resp_valid) begin
                        state_nxt      = DRAIN;
                        drain_addr_nxt = mem_addr;
                    end
                end else if (resp_take) begin
                    if (word_sel == '0) begin
                        pc_nxt = pc_inc;
                    end else begin
                        instruction_nxt    = word_sel;
                        instruction_pc_nxt = pc;
                        state_nxt          = HOLD;
                    end
                end else if (req_en && buf_hit) begin
                    if (buf_word == '0) begin
                        pc_nxt = pc_inc;
                    end else begin
                        instruction_nxt    = buf_word;
                        instruction_pc_nxt = pc;
                        state_nxt          = HOLD;
                    end
                end
            end
            DRAIN: begin
                if (redirect_valid) begin
                    pc_nxt = redirect_tgt;
                end
                if (mem_resp_valid) begin
                    state_nxt = FETCH;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_nxt          = redirect_tgt;
                    instruction_nxt = '0;
                    state_nxt       = FETCH;
                end else if (decode_ready && (instruction != '0)) begin
                    pc_nxt          = pc_inc;
                    instruction_nxt = '0;
                    state_nxt       = FETCH;
                end
            end
            default: begin
                state_nxt = FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_pipeline_fetch.sv
// Directed bench for pipeline_fetch with RESET_PC=0x1000; expectations follow FETCH_LINE_BUFFER_EN.
module tb_pipeline_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_resp_valid;
    logic [63:0] mem_rdata;
    logic        decode_ready;
    logic [31:0] instruction;
    logic [63:0] instruction_pc;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    int tests = 0;
    int fails = 0;
    int req_count = 0;
    logic req_prev = 1'b0;

    pipeline_fetch #(
        .ADDR_WIDTH(64),
        .DATA_WIDTH(64),
        .RESET_PC  (64'h1000)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_resp_valid(mem_resp_valid),
        .mem_rdata     (mem_rdata),
        .decode_ready  (decode_ready),
        .instruction   (instruction),
        .instruction_pc(instruction_pc),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc)
    );

    always #5 clk = ~clk;

    // counts distinct request episodes (rising edges of mem_req)
    always @(negedge clk) begin
        if (mem_req && !req_prev) req_count++;
        req_prev = mem_req;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset          = 1'b0;
        mem_resp_valid = 1'b0;
        mem_rdata      = '0;
        decode_ready   = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        tick;
        tick;
        chk("rst_req",   64'(mem_req), 64'd0);
        chk("rst_instr", 64'(instruction), 64'd0);
        chk("rst_ipc",   instruction_pc, 64'h1000);

        reset = 1'b1;
        tick;
        chk("first_req",  64'(mem_req), 64'd1);
        chk("first_addr", mem_addr, 64'h1000);
        tick;
        chk("req_held",  64'(mem_req), 64'd1);
        chk("addr_held", mem_addr, 64'h1000);
        mem_resp_valid = 1'b1;
        mem_rdata      = 64'h00500093_00100093;
        tick;
        mem_resp_valid = 1'b0;
        chk("i0_instr", 64'(instruction), 64'h00100093);
        chk("i0_ipc",   instruction_pc, 64'h1000);

        for (int i = 0; i < 5; i++) begin
            tick;
            chk("stall_instr", 64'(instruction), 64'h00100093);
            chk("stall_ipc",   instruction_pc, 64'h1000);
            chk("stall_req",   64'(mem_req), 64'd0);
        end

        decode_ready = 1'b1;
        tick;
        decode_ready = 1'b0;
        chk("consume0_instr", 64'(instruction), 64'd0);
`ifdef FETCH_LINE_BUFFER_EN
        chk("consume0_req", 64'(mem_req), 64'd0);
        tick;
`else
        chk("consume0_req",  64'(mem_req), 64'd1);
        chk("consume0_addr", mem_addr, 64'h1000);
        mem_resp_valid = 1'b1;
        tick;
        mem_resp_valid = 1'b0;
`endif
        chk("i1_instr", 64'(instruction), 64'h00500093);
        chk("i1_ipc",   instruction_pc, 64'h1004);
`ifdef FETCH_LINE_BUFFER_EN
        chk("req_episodes", 64'(req_count), 64'd1);
`else
        chk("req_episodes", 64'(req_count), 64'd2);
`endif

        decode_ready = 1'b1;
        tick;
        decode_ready = 1'b0;
        chk("consume1_req",  64'(mem_req), 64'd1);
        chk("consume1_addr", mem_addr, 64'h1008);

        redirect_valid = 1'b1;
        redirect_pc    = 64'h2006;
        tick;
        redirect_valid = 1'b0;
        chk("drain_req",   64'(mem_req), 64'd1);
        chk("drain_addr",  mem_addr, 64'h1008);
        chk("drain_instr", 64'(instruction), 64'd0);
        mem_resp_valid = 1'b1;
        mem_rdata      = 64'h00600093_00600093;
        tick;
        mem_resp_valid = 1'b0;
        chk("drained_instr", 64'(instruction), 64'd0);
        chk("drained_req",   64'(mem_req), 64'd1);
        chk("drained_addr",  mem_addr, 64'h2000);
        mem_resp_valid = 1'b1;
        mem_rdata      = 64'h00300093_00000013;
        tick;
        mem_resp_valid = 1'b0;
        chk("redir_instr", 64'(instruction), 64'h00300093);
        chk("redir_ipc",   instruction_pc, 64'h2004);

        decode_ready = 1'b1;
        tick;
        decode_ready = 1'b0;
        chk("pre_coll_addr", mem_addr, 64'h2008);
        mem_resp_valid = 1'b1;
        mem_rdata      = 64'h00400093_00400093;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h3000;
        tick;
        mem_resp_valid = 1'b0;
        redirect_valid = 1'b0;
        chk("coll_instr", 64'(instruction), 64'd0);
        chk("coll_req",   64'(mem_req), 64'd1);
        chk("coll_addr",  mem_addr, 64'h3000);
        tick;
        chk("coll_instr_later", 64'(instruction), 64'd0);
        mem_resp_valid = 1'b1;
        mem_rdata      = 64'h00000000_00700093;
        tick;
        mem_resp_valid = 1'b0;
        chk("coll_resume_instr", 64'(instruction), 64'h00700093);
        chk("coll_resume_ipc",   instruction_pc, 64'h3000);

        redirect_valid = 1'b1;
        redirect_pc    = 64'h4001;
        tick;
        chk("hold_redir_instr", 64'(instruction), 64'd0);
        chk("hold_redir_req",   64'(mem_req), 64'd1);
        chk("hold_redir_addr",  mem_addr, 64'h4000);
        redirect_pc = 64'h5000;
        tick;
        chk("multi_drain_addr", mem_addr, 64'h4000);
        redirect_pc = 64'h6004;
        tick;
        redirect_valid = 1'b0;
        chk("multi_drain_addr2", mem_addr, 64'h4000);
        mem_resp_valid = 1'b1;
        mem_rdata      = 64'h00800093_00800093;
        tick;
        chk("multi_after_instr", 64'(instruction), 64'd0);
        chk("multi_after_addr",  mem_addr, 64'h6000);
        mem_rdata = 64'h00900093_00000000;
        tick;
        mem_resp_valid = 1'b0;
        chk("last_wins_instr", 64'(instruction), 64'h00900093);
        chk("last_wins_ipc",   instruction_pc, 64'h6004);

        decode_ready = 1'b1;
        tick;
        decode_ready = 1'b0;
        chk("pre_bubble_addr", mem_addr, 64'h6008);
        mem_resp_valid = 1'b1;
        mem_rdata      = 64'h00a00093_00000000;
        tick;
        mem_resp_valid = 1'b0;
        chk("bubble_instr", 64'(instruction), 64'd0);
`ifdef FETCH_LINE_BUFFER_EN
        chk("bubble_req", 64'(mem_req), 64'd0);
        tick;
`else
        chk("bubble_req",  64'(mem_req), 64'd1);
        chk("bubble_addr", mem_addr, 64'h6008);
        mem_resp_valid = 1'b1;
        tick;
        mem_resp_valid = 1'b0;
`endif
        chk("post_bubble_instr", 64'(instruction), 64'h00a00093);
        chk("post_bubble_ipc",   instruction_pc, 64'h600C);

        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFE;
        tick;
        redirect_valid = 1'b0;
        chk("top_addr", mem_addr, 64'hFFFF_FFFF_FFFF_FFF8);
        mem_resp_valid = 1'b1;
        mem_rdata      = 64'h00b00093_00000000;
        tick;
        mem_resp_valid = 1'b0;
        chk("top_instr", 64'(instruction), 64'h00b00093);
        chk("top_ipc",   instruction_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        decode_ready = 1'b1;
        tick;
        decode_ready = 1'b0;
        chk("wrap_req",  64'(mem_req), 64'd1);
        chk("wrap_addr", mem_addr, 64'h0);

        #3;
        reset = 1'b0;
        #1;
        chk("async_rst_req",   64'(mem_req), 64'd0);
        chk("async_rst_instr", 64'(instruction), 64'd0);
        chk("async_rst_ipc",   instruction_pc, 64'h1000);
        chk("async_rst_addr",  mem_addr, 64'h1000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipeline_fetch.md
PIPELINE_FETCH -- requirements
Module: pipeline_fetch

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64, PC/address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, memory read width; one beat holds two 32-bit instructions.
REQ-003 SHALL have parameter RESET_PC, default 0, first fetch address.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port mem_req  output  1  instruction-memory read request.
REQ-007 SHALL have port mem_addr  output  ADDR_WIDTH  request address, bits [2:0] always zero.
REQ-008 SHALL have port mem_resp_valid  input  1  one-cycle pulse, read data valid.
REQ-009 SHALL have port mem_rdata  input  DATA_WIDTH  read data; low half is the word at +0, high half the word at +4.
REQ-010 SHALL have port decode_ready  input  1  decode stage accepts the current instruction.
REQ-011 SHALL have port instruction  output  DATA_WIDTH/2  fetched instruction; 0 means bubble.
REQ-012 SHALL have port instruction_pc  output  ADDR_WIDTH  address of instruction.
REQ-013 SHALL have port redirect_valid  input  1  branch/jump redirect from a later stage.
REQ-014 SHALL have port redirect_pc  input  ADDR_WIDTH  redirect target.

Function
REQ-015 SHALL implement an FSM with states FETCH (mem_req high), DRAIN (mem_req high, response to be discarded) and HOLD (instruction presented).
REQ-016 SHALL hold mem_addr equal to {pc[ADDR_WIDTH-1:3],3'b000} and keep it stable while mem_req is high.
REQ-017 SHALL allow at most one outstanding request; mem_req stays high until the mem_resp_valid cycle.
REQ-018 SHALL, on mem_resp_valid in FETCH, register mem_rdata[31:0] if pc[2]=0, else mem_rdata[63:32], into instruction, with instruction_pc=pc on the next cycle, and go to HOLD.
REQ-019 SHALL have a latency of one cycle from the mem_resp_valid edge to a valid instruction.
REQ-020 SHALL treat an instruction as consumed at a rising edge where instruction!=0 and decode_ready=1, then set pc=pc+4 (modulo 2^ADDR_WIDTH) and drive instruction=0 next cycle.
REQ-021 SHALL hold instruction and instruction_pc stable in HOLD while decode_ready=0.
REQ-022 SHALL treat a fetched all-zero word as a bubble and auto-advance pc by 4 without waiting on decode_ready.
REQ-023 SHALL, on redirect_valid, load pc={redirect_pc[ADDR_WIDTH-1:2],2'b00} and drive instruction=0 next cycle.
REQ-024 SHALL go directly to FETCH on a redirect in HOLD.
REQ-025 SHALL go to DRAIN on a redirect in FETCH.
REQ-026 SHALL, in DRAIN, keep the old mem_addr until mem_resp_valid, discard the data, then enter FETCH with the new pc.
REQ-027 SHALL give redirect_valid priority over a simultaneous consume or mem_resp_valid; the response is discarded and never presented.
REQ-028 SHALL make the last redirect in DRAIN win when several redirects arrive before the response.
REQ-029 SHALL wrap pc 0xFFFF_FFFF_FFFF_FFFC+4 to 0 with no error.

Reset
REQ-030 SHALL, while reset=0, force pc=RESET_PC, state=FETCH, instruction=0, instruction_pc=RESET_PC, mem_req=0, and clear the line-buffer valid bit.
REQ-031 SHALL assert mem_req on the first rising clk edge after reset deasserts.
REQ-032 SHALL abandon an in-flight request on reset; a mem_resp_valid arriving after reset for that request is the memory's responsibility and is not masked.

Configuration
REQ-033 SHALL, with macro FETCH_LINE_BUFFER_EN defined, retain the last DATA_WIDTH beat plus tag pc[ADDR_WIDTH-1:3] and valid bit.
REQ-034 SHALL, with FETCH_LINE_BUFFER_EN defined, serve a next pc that hits the tag from the buffer without mem_req, presenting instruction one cycle after the consume or redirect.
REQ-035 SHALL, with FETCH_LINE_BUFFER_EN defined, invalidate the buffer only on reset.
REQ-036 SHALL, with FETCH_LINE_BUFFER_EN undefined, issue one memory request per instruction and contain no buffer storage.

Verification
REQ-037 SHALL cover: reset release, RESET_PC=0x1000, resp 2 cycles later with rdata=0x00500093_00100093 -> mem_addr=0x1000; instruction=0x00100093, pc 0x1000; then 0x00500093, pc 0x1004.
REQ-038 SHALL cover: decode_ready=0 for 5 cycles in HOLD -> instruction/instruction_pc unchanged, no mem_req; consume on ready=1.
REQ-039 SHALL cover: redirect_valid with redirect_pc=0x2006 during FETCH -> DRAIN, old response discarded, next mem_addr=0x2000, instruction_pc=0x2004.
REQ-040 SHALL cover: redirect and mem_resp_valid in the same cycle -> response never presented, fetch resumes at the redirect target.
REQ-041 SHALL cover: with FETCH_LINE_BUFFER_EN, sequential pc 0x1000->0x1004 -> one mem_req total; without it, two.
REQ-042 SHALL cover: reset asserted mid-FETCH -> mem_req=0 and instruction=0 immediately, without waiting for clk.
